// File: rtl/receiver.sv
// UART 8N1 receive path: 16x-oversampled start/data/stop recovery feeding the RX FIFO write port.
// Define RX_MAJORITY_EN to make every bit decision a 2-of-3 vote over the last three synchronised samples.
module receiver #(
  parameter int unsigned OS  = 16,
  parameter int unsigned MID = OS / 2 - 1
) (
  input  logic       uart_clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  input  logic       rf_full,
  output logic       rf_wrreq,
  output logic [7:0] rf_data,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       rx_busy
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DATA_W = 8;
  localparam logic [CNT_W-1:0] START_PT = CNT_W'(MID);
  localparam logic [CNT_W-1:0] STOP_PT  = CNT_W'(MID + OS * 9);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   rf_data_q, rf_data_d;
  logic                rf_wrreq_q, rf_wrreq_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_err_q, overrun_err_d;
  logic                rx_busy_q, rx_busy_d;
  logic                rxd_meta_q, rxd_s_q, rxd_h1_q;
  logic                bit_val_c;
  logic [CNT_W-1:0]    data_pt_c;

  // Two-FF synchroniser plus one-cycle history; all reset high so the line looks idle.
`ifdef RX_MAJORITY_EN
  logic rxd_h2_q;

  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) rxd_h2_q <= 1'b1;
    else        rxd_h2_q <= rxd_h1_q;
  end

  assign bit_val_c = (rxd_s_q & rxd_h1_q) | (rxd_s_q & rxd_h2_q) | (rxd_h1_q & rxd_h2_q);
`else
  assign bit_val_c = rxd_s_q;
`endif

  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      rxd_h1_q   <= 1'b1;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_s_q    <= rxd_meta_q;
      rxd_h1_q   <= rxd_s_q;
    end
  end

  assign data_pt_c = CNT_W'(MID + OS * (32'(bit_q) + 32'd1));

  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      rf_data_q     <= '0;
      rf_wrreq_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
      rx_busy_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      rf_data_q     <= rf_data_d;
      rf_wrreq_q    <= rf_wrreq_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
      rx_busy_q     <= rx_busy_d;
    end
  end

  // Frame sequencing; cnt runs from the start edge so every sample point is absolute.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    rf_data_d     = rf_data_q;
    rf_wrreq_d    = 1'b0;
    frame_err_d   = 1'b0;
    overrun_err_d = 1'b0;
    rx_busy_d     = rx_busy_q;
    unique case (state_q)
      IDLE: begin
        if (rxd_h1_q && !rxd_s_q) begin
          state_d   = START;
          cnt_d     = '0;
          rx_busy_d = 1'b1;
        end
      end
      START: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == START_PT) begin
          if (bit_val_c) begin
            state_d   = IDLE;
            rx_busy_d = 1'b0;
          end else begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
      end
      DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == data_pt_c) begin
          shift_d = {bit_val_c, shift_q[DATA_W-1:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == STOP_PT) begin
          state_d   = IDLE;
          rx_busy_d = 1'b0;
          if (!bit_val_c) begin
            frame_err_d = 1'b1;
          end else if (rf_full) begin
            overrun_err_d = 1'b1;
          end else begin
            rf_wrreq_d = 1'b1;
            rf_data_d  = shift_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rf_wrreq    = rf_wrreq_q;
  assign rf_data     = rf_data_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
  assign rx_busy     = rx_busy_q;

endmodule

// File: tb/tb_receiver.sv
// Randomised scoreboard bench for receiver: frame-level outcome model, decoupled event monitor.
`timescale 1ns/1ps
module tb_receiver;

  localparam int unsigned OS = 16;
  localparam int K_WR   = 0;
  localparam int K_FERR = 1;
  localparam int K_OVR  = 2;

  logic       uart_clk = 1'b0;
  logic       rst_n    = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       rf_full  = 1'b0;
  logic       rf_wrreq;
  logic [7:0] rf_data;
  logic       frame_err;
  logic       overrun_err;
  logic       rx_busy;

  receiver #(.OS(OS), .MID(OS / 2 - 1)) dut (
    .uart_clk   (uart_clk),
    .rst_n      (rst_n),
    .uart_rxd   (uart_rxd),
    .rf_full    (rf_full),
    .rf_wrreq   (rf_wrreq),
    .rf_data    (rf_data),
    .frame_err  (frame_err),
    .overrun_err(overrun_err),
    .rx_busy    (rx_busy)
  );

  always #5 uart_clk = ~uart_clk;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  int         wr_cyc_q[$];
  int         checks = 0;
  int         passes = 0;
  int         cyc = 0;
  bit         busy_seen = 1'b0;
  bit         prev_evt = 1'b0;
  logic [7:0] model_last_wr = 8'h00;

  always @(posedge uart_clk) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok, input int act, input int exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
  endtask

  // Frame-level reference: outcome depends only on the stop bit and FIFO state.
  task automatic expect_frame(input logic [7:0] b, input bit stop, input bit full);
    exp_t e;
    if (!stop)     e.kind = K_FERR;
    else if (full) e.kind = K_OVR;
    else           e.kind = K_WR;
    e.data = (e.kind == K_WR) ? b : model_last_wr;
    if (e.kind == K_WR) model_last_wr = b;
    exp_q.push_back(e);
  endtask

  task automatic drive_bit(input logic v);
    uart_rxd = v;
    repeat (OS) @(negedge uart_clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge uart_clk);
    repeat (4) @(negedge uart_clk);
    check("drain_pending", exp_q.size() == 0, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: pops one expectation per output event.
  always @(posedge uart_clk) begin
    int   np;
    int   kind_act;
    exp_t e;
    #1;
    if (rst_n) begin
      np = int'(rf_wrreq) + int'(frame_err) + int'(overrun_err);
      if (np > 0) begin
        check("single_event", np == 1, np, 1);
        check("pulse_width", !prev_evt, int'(prev_evt), 0);
        check("busy_cleared", rx_busy == 1'b0, int'(rx_busy), 0);
        kind_act = rf_wrreq ? K_WR : (frame_err ? K_FERR : K_OVR);
        if (exp_q.size() == 0) begin
          check("unexpected_event", 1'b0, kind_act, -1);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", kind_act == e.kind, kind_act, e.kind);
          if (e.kind != K_FERR) check("rf_data", rf_data == e.data, int'(rf_data), int'(e.data));
        end
        if (rf_wrreq) wr_cyc_q.push_back(cyc);
      end
      prev_evt = (np > 0);
      if (rx_busy) busy_seen = 1'b1;
    end else begin
      prev_evt = 1'b0;
    end
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int start_cyc;
    rst_n = 1'b0;
    repeat (5) @(negedge uart_clk);
    check("rst_wrreq", rf_wrreq == 1'b0, int'(rf_wrreq), 0);
    check("rst_data", rf_data == 8'h00, int'(rf_data), 0);
    check("rst_ferr", frame_err == 1'b0, int'(frame_err), 0);
    check("rst_ovr", overrun_err == 1'b0, int'(overrun_err), 0);
    check("rst_busy", rx_busy == 1'b0, int'(rx_busy), 0);
    rst_n = 1'b1;
    repeat (3) drive_bit(1'b1);

    // Single good frame with latency from start edge to write strobe
    wr_cyc_q.delete();
    rf_full = 1'b0;
    start_cyc = cyc;
    expect_frame(8'hA5, 1'b1, 1'b0);
    send_frame(8'hA5, 1'b1);
    repeat (2) drive_bit(1'b1);
    drain(400);
    check("a5_write_count", wr_cyc_q.size() == 1, wr_cyc_q.size(), 1);
    if (wr_cyc_q.size() == 1)
      check("a5_latency", (wr_cyc_q[0] - start_cyc) >= 154 && (wr_cyc_q[0] - start_cyc) <= 156,
            wr_cyc_q[0] - start_cyc, 155);

    // Back-to-back frames, second start right after the stop bit
    wr_cyc_q.delete();
    expect_frame(8'h00, 1'b1, 1'b0);
    expect_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (2) drive_bit(1'b1);
    drain(400);
    check("b2b_write_count", wr_cyc_q.size() == 2, wr_cyc_q.size(), 2);
    if (wr_cyc_q.size() == 2)
      check("b2b_spacing", (wr_cyc_q[1] - wr_cyc_q[0]) == 160, wr_cyc_q[1] - wr_cyc_q[0], 160);

    // Short low glitch on an idle line
    busy_seen = 1'b0;
    uart_rxd = 1'b0;
    repeat (4) @(negedge uart_clk);
    uart_rxd = 1'b1;
    repeat (40) @(negedge uart_clk);
    check("glitch_busy_seen", busy_seen == 1'b1, int'(busy_seen), 1);
    check("glitch_busy_idle", rx_busy == 1'b0, int'(rx_busy), 0);
    drive_bit(1'b1);

    // Bad stop bit, then recovery
    expect_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0);
    repeat (2) drive_bit(1'b1);
    expect_frame(8'h55, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1);
    repeat (2) drive_bit(1'b1);
    drain(400);

    // FIFO full: frame dropped, data held
    rf_full = 1'b1;
    expect_frame(8'h81, 1'b1, 1'b1);
    send_frame(8'h81, 1'b1);
    repeat (2) drive_bit(1'b1);
    rf_full = 1'b0;
    drain(400);

    // Reset in the middle of a frame
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h7E >> i));
    uart_rxd = 1'b1;
    repeat (OS / 2) @(negedge uart_clk);
    check("mid_busy_before_rst", rx_busy == 1'b1, int'(rx_busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", rx_busy == 1'b0, int'(rx_busy), 0);
    check("mid_rst_data", rf_data == 8'h00, int'(rf_data), 0);
    check("mid_rst_wrreq", rf_wrreq == 1'b0, int'(rf_wrreq), 0);
    model_last_wr = 8'h00;
    repeat (3) @(negedge uart_clk);
    rst_n = 1'b1;
    repeat (2) drive_bit(1'b1);
    expect_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h12, 1'b1);
    repeat (2) drive_bit(1'b1);
    drain(400);

    // Break: line held low reports one framing error only
    expect_frame(8'h00, 1'b0, 1'b0);
    uart_rxd = 1'b0;
    repeat (30 * OS) @(negedge uart_clk);
    repeat (2) drive_bit(1'b1);
    expect_frame(8'h5A, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b1);
    repeat (2) drive_bit(1'b1);
    drain(400);

`ifdef RX_MAJORITY_EN
    // One-clock low spike at the centre of a '1' data bit is voted out
    expect_frame(8'hFF, 1'b1, 1'b0);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        uart_rxd = 1'b1;
        repeat (OS / 2) @(negedge uart_clk);
        uart_rxd = 1'b0;
        @(negedge uart_clk);
        uart_rxd = 1'b1;
        repeat (OS / 2 - 1) @(negedge uart_clk);
      end else begin
        drive_bit(1'b1);
      end
    end
    drive_bit(1'b1);
    repeat (2) drive_bit(1'b1);
    drain(400);
`endif

    // Randomised frames: byte, stop bit, FIFO state and idle gap all random
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      bit         stop;
      bit         full;
      int         gap;
      b    = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      full = ($urandom_range(0, 3) == 0);
      gap  = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      rf_full = full;
      expect_frame(b, stop, full);
      send_frame(b, stop);
      for (int g = 0; g < gap; g++) drive_bit(1'b1);
    end
    repeat (2) drive_bit(1'b1);
    rf_full = 1'b0;
    drain(600);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
